sram_slot_arbiter: RTL and testbench
====================================

// Module: sram_slot_arbiter
// PURPOSE
//  Time-slot arbiter for the single external 8-bit SRAM. Performs the power-on read of the
//  video-config byte, then alternates fixed slots between the machine core (even) and the
//  control-module host port (odd) used for ROM/disk image DMA.
//  Sits between the machine core, the control module and the top-level sram_data tri-state.
// PARAMETERS
//  CFG_ADDR     21'h008FD5  SRAM address of boot config byte (scandoubler/scanline bits)
//  BOOT_DELAY   8           clk24 cycles CFG_ADDR is held before sampling (>=2)
//  CFG_DEFAULT  8'h00       cfg_byte value when boot read is compiled out
// PORTS
//  clk24           in   1   single clock, SRAM multiplexer clock
//  reset_n         in   1   asynchronous, active-low reset
//  mach_addr       in   19  machine address, zero-extended to 21 bits
//  mach_we_n       in   1   machine write strobe, sampled only in machine slot
//  mach_wdata      in   8   machine write data
//  mach_rdata      out  8   machine read data, registered at end of machine slot
//  mach_phase      out  1   0 = machine slot in progress; machine core aligns clk12 edges to it
//  machine_reset_n out  1   low until boot config captured
//  host_strobe     in   1   1-cycle request; addr/we/wdata captured on same edge
//  host_we         in   1   1 = write, 0 = read
//  host_addr       in   21  host address (full 2 MB)
//  host_wdata      in   8   host write data
//  host_busy       out  1   request pending or in flight
//  host_ack        out  1   1-cycle pulse, access complete
//  host_rdata      out  8   read data, valid with host_ack, held until next read
//  sram_addr       out  21  to SRAM
//  sram_we_n       out  1   to SRAM
//  sram_dout       out  8   write data to top-level tri-state
//  sram_doe        out  1   1 = top level drives sram_data with sram_dout
//  sram_din        in   8   sram_data as read
//  cfg_byte        out  8   captured config byte
//  cfg_valid       out  1   cfg_byte valid
// BEHAVIOUR
//  Reset values: sram_addr=CFG_ADDR, sram_we_n=1, sram_doe=0, machine_reset_n=0, cfg_valid=0,
//   cfg_byte=0, host_busy=0, host_ack=0, host_rdata=0, mach_rdata=0, mach_phase=0.
//  States: BOOT_WAIT -> BOOT_SAMPLE -> RUN. Reset (any time) returns to BOOT_WAIT and drops pending request.
//  BOOT_WAIT: addr=CFG_ADDR, we_n=1, count BOOT_DELAY cycles. BOOT_SAMPLE: cfg_byte<=sram_din,
//   cfg_valid<=1, machine_reset_n<=1 on the next edge; enter RUN with mach_phase=0.
//  RUN: mach_phase toggles every clk24. Phase 0: addr={2'b00,mach_addr}, we_n=mach_we_n,
//   doe=~mach_we_n, dout=mach_wdata; at phase end mach_rdata<=sram_din (reads only).
//  Phase 1: if request pending: addr=host_addr, we_n=~host_we, doe=host_we; at phase end
//   host_rdata<=sram_din (reads), host_ack=1 for the next cycle, busy clears with ack. Else we_n=1, doe=0.
//  Host latency: ack 2-3 cycles after strobe (depends on phase). Strobe while busy is ignored.
//  Strobe in the same cycle as ack is accepted (back-to-back, one access per 2 cycles max).
//  Strobe during BOOT states is captured, served in first host slot of RUN.
//  Machine never stalled; host never starves (one guaranteed slot per 2 cycles).
// CONFIGURATION
//  SRAM_ARB_BOOTCFG_EN defined: boot read as above.
//  Undefined: BOOT_SAMPLE skips SRAM; cfg_byte=CFG_DEFAULT, cfg_valid=1 after BOOT_DELAY; slots unchanged.
// STRUCTURE
//  Package sram_arb_pkg: state enum (BOOT_WAIT/BOOT_SAMPLE/RUN), SLOT_MACH=0/SLOT_HOST=1,
//   address width constants (21/19).
//  One sub-module: sram_arb_host_req (strobe capture, busy/ack, rdata hold).
// TESTING
//  Boot: SRAM model[0x008FD5]=8'h03 -> cfg_byte=03, cfg_valid and machine_reset_n rise BOOT_DELAY+1 cycles after reset.
//  Machine write 0x12345<-A5 then read -> model updated in phase 0 only; mach_rdata=A5 next cycle.
//  Host write 0x1FFFFF<-5A, read back -> ack pulse each, host_rdata=5A; machine reads in between unaffected.
//  Back-to-back host strobes on ack cycles x8 -> 8 acks spaced 2 cycles; strobe while busy dropped.
//  Reset asserted mid host access -> no ack, busy=0, sram_we_n=1 immediately; boot sequence reruns.
//  SRAM_ARB_BOOTCFG_EN undefined, CFG_DEFAULT=8'h02 -> cfg_byte=02, no SRAM read cycle at CFG_ADDR sampled.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the external SRAM slot arbiter.
// The optional boot read of the config byte is enabled by defining SRAM_ARB_BOOTCFG_EN.
package sram_arb_pkg;

  localparam int SRAM_AW = 21;  // full 2 MB SRAM address
  localparam int MACH_AW = 19;  // machine core address, zero-extended onto the SRAM bus

  // Slot owner encoded on mach_phase while running
  localparam logic SLOT_MACH = 1'b0;
  localparam logic SLOT_HOST = 1'b1;

  typedef enum logic [1:0] {
    BOOT_WAIT   = 2'd0,
    BOOT_SAMPLE = 2'd1,
    RUN         = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram_arb_host_req.sv
// Host port request holder: captures one strobed access, keeps busy until its
// slot completes, pulses ack and holds the last read byte.
module sram_arb_host_req
  import sram_arb_pkg::*;
(
  input  logic               clk24,
  input  logic               reset_n,
  input  logic               host_strobe,
  input  logic               host_we,
  input  logic [SRAM_AW-1:0] host_addr,
  input  logic [7:0]         host_wdata,
  input  logic               host_slot_end,
  input  logic [7:0]         sram_din,
  output logic               host_busy,
  output logic               host_ack,
  output logic [7:0]         host_rdata,
  output logic               req_we,
  output logic [SRAM_AW-1:0] req_addr,
  output logic [7:0]         req_wdata
);

  logic               busy_r;
  logic               ack_r;
  logic [7:0]         rdata_r;
  logic               we_r;
  logic [SRAM_AW-1:0] addr_r;
  logic [7:0]         wdata_r;

  // Capture a strobe when idle; complete it at the end of its host slot.
  // Busy drops together with the ack edge, so a strobe in the ack cycle is taken.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
      rdata_r <= 8'h00;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 8'h00;
    end else begin
      ack_r <= 1'b0;
      if (host_slot_end && busy_r) begin
        busy_r <= 1'b0;
        ack_r  <= 1'b1;
        if (!we_r) begin
          rdata_r <= sram_din;
        end
      end else if (host_strobe && !busy_r) begin
        busy_r  <= 1'b1;
        we_r    <= host_we;
        addr_r  <= host_addr;
        wdata_r <= host_wdata;
      end
    end
  end

  assign host_busy  = busy_r;
  assign host_ack   = ack_r;
  assign host_rdata = rdata_r;
  assign req_we     = we_r;
  assign req_addr   = addr_r;
  assign req_wdata  = wdata_r;

endmodule

// File: rtl/sram_slot_arbiter.sv
// Time-slot arbiter for the single external 8-bit SRAM: power-on read of the
// video-config byte, then alternating machine (even) / host (odd) slots.
// Define SRAM_ARB_BOOTCFG_EN to read the config byte from SRAM at boot;
// otherwise CFG_DEFAULT is reported once the boot delay has elapsed.
module sram_slot_arbiter
  import sram_arb_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] CFG_ADDR    = 21'h008FD5,
  parameter int                 BOOT_DELAY  = 8,      // 2..256 cycles
  parameter logic [7:0]         CFG_DEFAULT = 8'h00
) (
  input  logic               clk24,
  input  logic               reset_n,
  input  logic [MACH_AW-1:0] mach_addr,
  input  logic               mach_we_n,
  input  logic [7:0]         mach_wdata,
  output logic [7:0]         mach_rdata,
  output logic               mach_phase,
  output logic               machine_reset_n,
  input  logic               host_strobe,
  input  logic               host_we,
  input  logic [SRAM_AW-1:0] host_addr,
  input  logic [7:0]         host_wdata,
  output logic               host_busy,
  output logic               host_ack,
  output logic [7:0]         host_rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [7:0]         sram_dout,
  output logic               sram_doe,
  input  logic [7:0]         sram_din,
  output logic [7:0]         cfg_byte,
  output logic               cfg_valid
);

`ifdef SRAM_ARB_BOOTCFG_EN
  localparam logic BOOTCFG_EN = 1'b1;
`else
  localparam logic BOOTCFG_EN = 1'b0;
`endif

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_DELAY - 1);

  arb_state_e         state_r, state_s;
  logic [7:0]         cnt_r, cnt_s;
  logic               phase_r, phase_s;
  logic [7:0]         cfg_byte_r;
  logic               cfg_valid_r;
  logic               mach_rst_n_r;
  logic [7:0]         mach_rdata_r;

  logic               host_slot_end_s;
  logic               req_we_s;
  logic [SRAM_AW-1:0] req_addr_s;
  logic [7:0]         req_wdata_s;

  logic [SRAM_AW-1:0] sram_addr_s;
  logic               sram_we_n_s;
  logic [7:0]         sram_dout_s;
  logic               sram_doe_s;

  // State, boot counter and slot phase registers.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= BOOT_WAIT;
      cnt_r   <= 8'd0;
      phase_r <= SLOT_MACH;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      phase_r <= phase_s;
    end
  end

  // Next state: hold CFG_ADDR for BOOT_DELAY cycles, one sample cycle, then alternate slots.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    phase_s = phase_r;
    case (state_r)
      BOOT_WAIT: begin
        phase_s = SLOT_MACH;
        if (cnt_r == BOOT_LAST) begin
          state_s = BOOT_SAMPLE;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      BOOT_SAMPLE: begin
        state_s = RUN;
        phase_s = SLOT_MACH;
      end
      RUN: begin
        phase_s = ~phase_r;
      end
      default: begin
        state_s = BOOT_WAIT;
        cnt_s   = 8'd0;
        phase_s = SLOT_MACH;
      end
    endcase
  end

  // Config capture releases the machine; machine read data lands at the end of its slot.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      cfg_byte_r   <= 8'h00;
      cfg_valid_r  <= 1'b0;
      mach_rst_n_r <= 1'b0;
      mach_rdata_r <= 8'h00;
    end else begin
      if (state_r == BOOT_SAMPLE) begin
        cfg_byte_r   <= BOOTCFG_EN ? sram_din : CFG_DEFAULT;
        cfg_valid_r  <= 1'b1;
        mach_rst_n_r <= 1'b1;
      end
      if ((state_r == RUN) && (phase_r == SLOT_MACH) && mach_we_n) begin
        mach_rdata_r <= sram_din;
      end
    end
  end

  assign host_slot_end_s = (state_r == RUN) && (phase_r == SLOT_HOST) && host_busy;

  sram_arb_host_req u_host_req (
    .clk24         (clk24),
    .reset_n       (reset_n),
    .host_strobe   (host_strobe),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_slot_end (host_slot_end_s),
    .sram_din      (sram_din),
    .host_busy     (host_busy),
    .host_ack      (host_ack),
    .host_rdata    (host_rdata),
    .req_we        (req_we_s),
    .req_addr      (req_addr_s),
    .req_wdata     (req_wdata_s)
  );

  // SRAM bus mux. The machine slot passes machine signals straight through so the
  // core sees a full clk24 period of access time without a pipeline stage.
  always_comb begin
    sram_addr_s = CFG_ADDR;
    sram_we_n_s = 1'b1;
    sram_dout_s = 8'h00;
    sram_doe_s  = 1'b0;
    if (state_r == RUN) begin
      if (phase_r == SLOT_MACH) begin
        sram_addr_s = {{(SRAM_AW-MACH_AW){1'b0}}, mach_addr};
        sram_we_n_s = mach_we_n;
        sram_dout_s = mach_wdata;
        sram_doe_s  = ~mach_we_n;
      end else if (host_busy) begin
        sram_addr_s = req_addr_s;
        sram_we_n_s = ~req_we_s;
        sram_dout_s = req_wdata_s;
        sram_doe_s  = req_we_s;
      end else begin
        sram_addr_s = req_addr_s;
        sram_we_n_s = 1'b1;
        sram_dout_s = 8'h00;
        sram_doe_s  = 1'b0;
      end
    end else begin
      sram_addr_s = CFG_ADDR;
      sram_we_n_s = 1'b1;
    end
  end

  assign sram_addr       = sram_addr_s;
  assign sram_we_n       = sram_we_n_s;
  assign sram_dout       = sram_dout_s;
  assign sram_doe        = sram_doe_s;
  assign mach_phase      = phase_r;
  assign machine_reset_n = mach_rst_n_r;
  assign mach_rdata      = mach_rdata_r;
  assign cfg_byte        = cfg_byte_r;
  assign cfg_valid       = cfg_valid_r;

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Self-checking bench for sram_slot_arbiter with a behavioural 2 MB SRAM model.
module tb_sram_slot_arbiter;

  localparam int          BOOT_DELAY_TB = 8;
  localparam logic [20:0] CFG_ADDR_TB   = 21'h008FD5;
  localparam logic [20:0] B2B_BASE      = 21'h100000;
`ifdef SRAM_ARB_BOOTCFG_EN
  localparam logic [7:0] EXP_CFG = 8'h03;
`else
  localparam logic [7:0] EXP_CFG = 8'h02;
`endif

  logic        clk24 = 1'b0;
  logic        reset_n = 1'b0;
  logic [18:0] mach_addr = '0;
  logic        mach_we_n = 1'b1;
  logic [7:0]  mach_wdata = 8'h00;
  logic [7:0]  mach_rdata;
  logic        mach_phase;
  logic        machine_reset_n;
  logic        host_strobe = 1'b0;
  logic        host_we = 1'b0;
  logic [20:0] host_addr = '0;
  logic [7:0]  host_wdata = 8'h00;
  logic        host_busy;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [20:0] sram_addr;
  logic        sram_we_n;
  logic [7:0]  sram_dout;
  logic        sram_doe;
  logic [7:0]  sram_din;
  logic [7:0]  cfg_byte;
  logic        cfg_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // SRAM model with a preload port
  logic [7:0]  mem [0:2097151];
  logic        pl_en = 1'b0;
  logic [20:0] pl_addr = '0;
  logic [7:0]  pl_data = 8'h00;

  always #5 clk24 = ~clk24;

  sram_slot_arbiter #(
    .CFG_ADDR    (CFG_ADDR_TB),
    .BOOT_DELAY  (BOOT_DELAY_TB),
    .CFG_DEFAULT (8'h02)
  ) dut (
    .clk24           (clk24),
    .reset_n         (reset_n),
    .mach_addr       (mach_addr),
    .mach_we_n       (mach_we_n),
    .mach_wdata      (mach_wdata),
    .mach_rdata      (mach_rdata),
    .mach_phase      (mach_phase),
    .machine_reset_n (machine_reset_n),
    .host_strobe     (host_strobe),
    .host_we         (host_we),
    .host_addr       (host_addr),
    .host_wdata      (host_wdata),
    .host_busy       (host_busy),
    .host_ack        (host_ack),
    .host_rdata      (host_rdata),
    .sram_addr       (sram_addr),
    .sram_we_n       (sram_we_n),
    .sram_dout       (sram_dout),
    .sram_doe        (sram_doe),
    .sram_din        (sram_din),
    .cfg_byte        (cfg_byte),
    .cfg_valid       (cfg_valid)
  );

  assign sram_din = mem[sram_addr];

  // SRAM write port plus bench preload
  always @(posedge clk24) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (sram_we_n == 1'b0) begin
      mem[sram_addr] <= sram_dout;
    end
  end

  typedef struct packed {
    logic [18:0] addr;
    logic        we_n;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
  } mvec_t;

  mvec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [20:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk24); #1;
    pl_en = 1'b0;
  endtask

  task automatic wait_phase0();
    int n = 0;
    @(negedge clk24);
    while (mach_phase !== 1'b0 && n < 4) begin
      @(negedge clk24);
      n++;
    end
    check("phase0_reached", {31'd0, mach_phase}, 32'd0);
  endtask

  // Called at a negedge with reset low; optionally strobes a host read during boot.
  task automatic run_boot(input bit strobe_in_boot);
    reset_n = 1'b1;
    for (int k = 1; k <= BOOT_DELAY_TB + 1; k++) begin
      @(posedge clk24); #1;
      if (strobe_in_boot && k == 1) begin
        host_strobe = 1'b1; host_we = 1'b0; host_addr = 21'h1FFFFF;
      end
      if (strobe_in_boot && k == 2) begin
        host_strobe = 1'b0;
        check("boot_strobe_busy", {31'd0, host_busy}, 32'd1);
      end
      if (k == BOOT_DELAY_TB) begin
        check("cfg_valid_early", {31'd0, cfg_valid}, 32'd0);
        check("mrst_early", {31'd0, machine_reset_n}, 32'd0);
        check("boot_addr", {11'd0, sram_addr}, {11'd0, CFG_ADDR_TB});
      end
    end
    check("cfg_valid", {31'd0, cfg_valid}, 32'd1);
    check("mrst_rise", {31'd0, machine_reset_n}, 32'd1);
    check("cfg_byte", {24'd0, cfg_byte}, {24'd0, EXP_CFG});
    check("run_phase0", {31'd0, mach_phase}, 32'd0);
  endtask

  task automatic host_op(input logic we, input logic [20:0] addr, input logic [7:0] wd,
                         input logic [7:0] exp_rd);
    int   lat;
    int   exp_lat;
    logic exp_wen;
    exp_wen = !we;
    @(negedge clk24);
    exp_lat = (mach_phase == 1'b0) ? 2 : 3;
    host_strobe = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    @(posedge clk24); #1;
    host_strobe = 1'b0;
    lat = 1;
    check("host_busy_set", {31'd0, host_busy}, 32'd1);
    while (!host_ack && lat < 6) begin
      @(negedge clk24);
      if (mach_phase == 1'b1) begin
        check("hslot_addr", {11'd0, sram_addr}, {11'd0, addr});
        check("hslot_we_n", {31'd0, sram_we_n}, {31'd0, exp_wen});
        check("hslot_doe", {31'd0, sram_doe}, {31'd0, we});
        if (we) check("hslot_dout", {24'd0, sram_dout}, {24'd0, wd});
      end
      @(posedge clk24); #1;
      lat++;
    end
    check("host_ack_seen", {31'd0, host_ack}, 32'd1);
    check("host_latency", lat, exp_lat);
    check("host_busy_clr", {31'd0, host_busy}, 32'd0);
    if (!we) check("host_rdata", {24'd0, host_rdata}, {24'd0, exp_rd});
    else     check("host_wr_mem", {24'd0, mem[addr]}, {24'd0, wd});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_mrd;
    int         acks;
    bit         exp_ack;

    vecs[0] = '{addr: 19'h12345, we_n: 1'b0, wdata: 8'hA5, exp_rd: 8'h00};
    vecs[1] = '{addr: 19'h12345, we_n: 1'b1, wdata: 8'h00, exp_rd: 8'hA5};
    vecs[2] = '{addr: 19'h00000, we_n: 1'b0, wdata: 8'h3C, exp_rd: 8'h00};
    vecs[3] = '{addr: 19'h7FFFF, we_n: 1'b0, wdata: 8'hC3, exp_rd: 8'h00};
    vecs[4] = '{addr: 19'h00000, we_n: 1'b1, wdata: 8'h00, exp_rd: 8'h3C};
    vecs[5] = '{addr: 19'h7FFFF, we_n: 1'b1, wdata: 8'h00, exp_rd: 8'hC3};
    vecs[6] = '{addr: 19'h08FD5, we_n: 1'b1, wdata: 8'h00, exp_rd: 8'h03};
    vecs[7] = '{addr: 19'h12345, we_n: 1'b1, wdata: 8'h00, exp_rd: 8'hA5};

    // Preload while in reset
    preload(CFG_ADDR_TB, 8'h03);
    preload(21'h000100, 8'h00);
    for (int j = 0; j < 16; j++) preload(B2B_BASE + 21'(j), 8'(8'h40 + j));

    // Reset values
    @(negedge clk24);
    check("rst_sram_addr", {11'd0, sram_addr}, {11'd0, CFG_ADDR_TB});
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_doe", {31'd0, sram_doe}, 32'd0);
    check("rst_mrst", {31'd0, machine_reset_n}, 32'd0);
    check("rst_cfg_valid", {31'd0, cfg_valid}, 32'd0);
    check("rst_cfg_byte", {24'd0, cfg_byte}, 32'd0);
    check("rst_busy", {31'd0, host_busy}, 32'd0);
    check("rst_ack", {31'd0, host_ack}, 32'd0);
    check("rst_hrdata", {24'd0, host_rdata}, 32'd0);
    check("rst_mrdata", {24'd0, mach_rdata}, 32'd0);
    check("rst_phase", {31'd0, mach_phase}, 32'd0);

    run_boot(1'b0);

    // Machine slot vectors
    exp_mrd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wait_phase0();
      mach_addr = vecs[i].addr; mach_we_n = vecs[i].we_n; mach_wdata = vecs[i].wdata;
      #1;
      check("m_addr", {11'd0, sram_addr}, {13'd0, vecs[i].addr});
      check("m_we_n", {31'd0, sram_we_n}, {31'd0, vecs[i].we_n});
      check("m_doe", {31'd0, sram_doe}, {31'd0, !vecs[i].we_n});
      if (!vecs[i].we_n) check("m_dout", {24'd0, sram_dout}, {24'd0, vecs[i].wdata});
      @(posedge clk24); #1;
      if (!vecs[i].we_n) begin
        check("m_wr_mem", {24'd0, mem[{2'b00, vecs[i].addr}]}, {24'd0, vecs[i].wdata});
        check("m_rdata_hold", {24'd0, mach_rdata}, {24'd0, exp_mrd});
        // Host slot: a held machine write must not reach the SRAM
        mach_wdata = ~vecs[i].wdata;
        check("m_host_slot_we_n", {31'd0, sram_we_n}, 32'd1);
        @(posedge clk24); #1;
        check("m_phase1_nowrite", {24'd0, mem[{2'b00, vecs[i].addr}]}, {24'd0, vecs[i].wdata});
      end else begin
        exp_mrd = vecs[i].exp_rd;
        check("m_rdata", {24'd0, mach_rdata}, {24'd0, exp_mrd});
        @(posedge clk24); #1;
      end
      mach_we_n = 1'b1;
    end

    // Host write/read at top of memory while the machine keeps reading 0x12345
    mach_addr = 19'h12345; mach_we_n = 1'b1;
    host_op(1'b1, 21'h1FFFFF, 8'h5A, 8'h00);
    host_op(1'b0, 21'h1FFFFF, 8'h00, 8'h5A);
    check("m_unaffected", {24'd0, mach_rdata}, 32'hA5);
    check("m_mem_unaffected", {24'd0, mem[21'h012345]}, 32'hA5);

    // Back-to-back strobes held high: accepted only on ack cycles
    repeat (2) @(posedge clk24);
    wait_phase0();
    acks = 0;
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) @(negedge clk24);
      exp_ack = (k >= 2) && (k <= 16) && (k % 2 == 0);
      check("b2b_ack", {31'd0, host_ack}, {31'd0, exp_ack});
      if (host_ack) acks++;
      if (exp_ack) check("b2b_rdata", {24'd0, host_rdata}, 32'h40 + 32'(k - 2));
      host_strobe = (k <= 14);
      host_we     = 1'b0;
      host_addr   = B2B_BASE + 21'(k);
    end
    host_strobe = 1'b0;
    check("b2b_ack_count", acks, 8);

    // Reset in the middle of a host write
    repeat (2) @(posedge clk24);
    wait_phase0();
    host_strobe = 1'b1; host_we = 1'b1; host_addr = 21'h000100; host_wdata = 8'h77;
    @(negedge clk24);
    host_strobe = 1'b0;
    #1;
    check("mid_we_active", {31'd0, sram_we_n}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, host_busy}, 32'd0);
    check("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("mid_rst_doe", {31'd0, sram_doe}, 32'd0);
    check("mid_rst_addr", {11'd0, sram_addr}, {11'd0, CFG_ADDR_TB});
    check("mid_rst_mrst", {31'd0, machine_reset_n}, 32'd0);
    check("mid_rst_valid", {31'd0, cfg_valid}, 32'd0);
    for (int r = 0; r < 3; r++) begin
      @(posedge clk24); #1;
      check("mid_rst_no_ack", {31'd0, host_ack}, 32'd0);
    end
    check("mid_rst_no_write", {24'd0, mem[21'h000100]}, 32'd0);
    @(negedge clk24);

    // Boot reruns; a strobe during boot is served in the first host slot
    run_boot(1'b1);
    @(posedge clk24); #1;
    check("boot_req_ack_early", {31'd0, host_ack}, 32'd0);
    check("boot_req_busy", {31'd0, host_busy}, 32'd1);
    check("boot_req_slot", {31'd0, mach_phase}, 32'd1);
    check("boot_req_addr", {11'd0, sram_addr}, 32'h1FFFFF);
    @(posedge clk24); #1;
    check("boot_req_ack", {31'd0, host_ack}, 32'd1);
    check("boot_req_rdata", {24'd0, host_rdata}, 32'h5A);
    check("boot_req_busy_clr", {31'd0, host_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
